macc_acc_requant: RTL and testbench
===================================

MACC_ACC_REQUANT -- requirements
Module: macc_acc_requant

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 20, meaning lane count of the upstream multiply-accumulate block.
REQ-002 SHALL have parameter IN_WIDTH, default 16+$clog2(NUM_INPUTS) (21), meaning signed partial-sum width.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, meaning accumulator and bias width.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, meaning pass-counter width.
REQ-005 SHALL have port clk  input  1  the only clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_data  input  IN_WIDTH  signed partial sum from the upstream multiply-accumulate block.
REQ-008 SHALL have port i_valid  input  1  i_data qualifier; there is no backpressure toward upstream.
REQ-009 SHALL have port i_num_pass  input  CNT_WIDTH  partial sums per output; 0 treated as 1.
REQ-010 SHALL have port i_bias  input  ACC_WIDTH  signed bias.
REQ-011 SHALL have port i_shift  input  5  requantization right-shift amount.
REQ-012 SHALL have port i_clear  input  1  synchronous flush.
REQ-013 SHALL have port o_data  output  8  signed requantized result.
REQ-014 SHALL have port o_valid  output  1  o_data valid.
REQ-015 SHALL have port i_ready  input  1  downstream accept; transfer occurs when o_valid && i_ready.
REQ-016 SHALL have port o_busy  output  1  high in ACCUM state or while any pipeline stage is occupied.
REQ-017 SHALL have port o_overflow  output  1  sticky flag: a result was dropped.

Function
REQ-018 SHALL implement states IDLE and ACCUM.
REQ-019 IDLE with i_valid SHALL load acc = i_bias + sext(i_data), latch i_num_pass, i_bias and i_shift, and set remaining = max(i_num_pass,1)-1.
REQ-020 Leaving IDLE SHALL go to ACCUM if remaining > 0; otherwise SHALL stay in IDLE and mark the sample as last.
REQ-021 ACCUM with i_valid SHALL set acc = acc + sext(i_data) and decrement remaining; on the sample that brings remaining to 0 it SHALL mark last and return to IDLE.
REQ-022 Cycles in ACCUM without i_valid SHALL hold all state; there is no timeout.
REQ-023 Accumulator arithmetic SHALL wrap modulo 2^ACC_WIDTH.
REQ-024 Stage 2 SHALL compute r = (acc + (shift>0 ? 2^(shift-1) : 0)) >>> shift in ACC_WIDTH+1 bits, rounding half toward +inf.
REQ-025 Stage 3 SHALL saturate r to [-128,127] and push the result to a 2-entry output FIFO.
REQ-026 Latency: if the last sample is sampled at edge N, o_valid SHALL be high after edge N+3 when the FIFO is not full.
REQ-027 Throughput SHALL be one partial sum per cycle, back-to-back across outputs with no bubble.
REQ-028 o_data/o_valid SHALL present the FIFO head and hold it stable until accepted.
REQ-029 A push while the FIFO is full and no pop occurs in the same cycle SHALL drop the new result and set o_overflow.
REQ-030 A push and pop in the same cycle while full SHALL succeed with no overflow.
REQ-031 i_clear SHALL empty the FIFO and pipeline, return to IDLE and clear o_overflow; an i_valid in the same cycle SHALL be discarded.
REQ-032 Config inputs SHALL be sampled only on the first partial of each output.

Reset
REQ-033 On rst_n low: state IDLE, acc 0, remaining 0, pipeline valids 0, FIFO empty, o_valid 0, o_data 0, o_busy 0, o_overflow 0.
REQ-034 Reset asserted mid-accumulation SHALL abandon the partial result; first i_valid after release starts a new output.
REQ-035 Only control and valid registers need reset; datapath registers may be non-reset.

Structure
REQ-036 A shared package macc_pkg SHALL hold the ACC_WIDTH/CNT_WIDTH defaults, the state enumeration, and the INT8_MIN/INT8_MAX constants.
REQ-037 The 2-entry FIFO SHALL be a sub-module macc_out_fifo (parameter WIDTH, push/pop/full/empty, clk/rst_n).

Verification
REQ-038 num_pass=3, bias=100, shift=2, partials 200,-50,30 back-to-back -> o_data=70 three cycles after the third partial.
REQ-039 num_pass=1, bias=0, shift=0, partial 1000 then -1000 -> o_data 127 then -128; partial -6 with shift=2 -> -1.
REQ-040 num_pass=0, bias=5, shift=0, partial 3 -> treated as one pass, o_data=8.
REQ-041 i_ready=0, four single-pass outputs -> two held in FIFO, o_overflow=1; raising i_ready drains exactly 2 results in order.
REQ-042 FIFO full with i_ready=1 and a push in the same cycle -> no drop, o_overflow stays 0.
REQ-043 Reset or i_clear after 2 of 4 partials, then a fresh 4-pass sequence -> only the fresh result appears, computed with newly sampled bias and shift.

Source files
------------

// File: rtl/macc_pkg.sv
// Shared definitions for the accumulate/requantize block.
//   ACC_WIDTH_DEF / CNT_WIDTH_DEF : default accumulator and pass-counter widths
//   state_e                       : accumulation FSM states
//   INT8_MIN / INT8_MAX           : saturation limits of the int8 result
package macc_pkg;

   localparam int ACC_WIDTH_DEF = 32;
   localparam int CNT_WIDTH_DEF = 8;

   localparam int INT8_MIN = -128;
   localparam int INT8_MAX = 127;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_e;

endpackage

// File: rtl/macc_out_fifo.sv
// Two-entry output FIFO for requantized results.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous empty
//   push/wr_data, pop/rd_data : write and read sides (rd_data is the head, 0 when empty)
//   full/empty : occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
module macc_out_fifo #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       cnt_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt_q == 2'd2);
   assign empty   = (cnt_q == 2'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else if (flush) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (do_push) wr_ptr_q <= ~wr_ptr_q;
         if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
         if (do_push && !do_pop)      cnt_q <= cnt_q + 2'd1;
         else if (do_pop && !do_push) cnt_q <= cnt_q - 2'd1;
      end
   end

   // When full, push and pop in the same cycle hit the same slot; the head is
   // read combinationally before the edge, so overwriting it here is safe.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/macc_acc_requant.sv
// Accumulates NUM_PASS signed partial sums plus a bias, then rounds, shifts
// and saturates the total to int8 into a 2-entry output FIFO.
//   clk, rst_n          : clock, async active-low reset
//   i_data, i_valid     : partial-sum stream (no backpressure)
//   i_num_pass, i_bias, i_shift : per-output config, taken on the first partial
//   i_clear             : synchronous flush of FSM, pipeline, FIFO and overflow flag
//   o_data, o_valid, i_ready : result stream (FIFO head)
//   o_busy              : accumulating or a pipeline stage occupied
//   o_overflow          : sticky, a result was dropped at a full FIFO
//
// state    | meaning
// ST_IDLE  | waiting for the first partial of an output
// ST_ACCUM | first partial taken, remaining partials outstanding
module macc_acc_requant
   import macc_pkg::*;
#(
   parameter int NUM_INPUTS = 20,
   parameter int IN_WIDTH   = 16 + $clog2(NUM_INPUTS),
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [IN_WIDTH-1:0]  i_data,
   input  logic                        i_valid,
   input  logic        [CNT_WIDTH-1:0] i_num_pass,
   input  logic signed [ACC_WIDTH-1:0] i_bias,
   input  logic        [4:0]           i_shift,
   input  logic                        i_clear,
   output logic signed [7:0]           o_data,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic                        o_busy,
   output logic                        o_overflow
);

   state_e                      state_q;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic        [CNT_WIDTH-1:0] rem_q;
   logic                        last_q;
   logic        [4:0]           shift_q;
   logic signed [ACC_WIDTH-1:0] data_sext;

   logic signed [ACC_WIDTH:0]   acc_ext;
   logic signed [ACC_WIDTH:0]   rnd;
   logic signed [ACC_WIDTH:0]   r_d;
   logic signed [ACC_WIDTH:0]   r_q;
   logic                        s2_vld_q;
   logic signed [7:0]           sat_d;
   logic signed [7:0]           sat_q;
   logic                        s3_vld_q;

   logic                        fifo_full;
   logic                        fifo_empty;
   logic                        fifo_pop;
   logic                        ovf_q;

   assign data_sext = ACC_WIDTH'(i_data);

   // Bias is folded into the accumulator on the first partial, so it needs no
   // separate copy; the shift is kept because stage 2 uses it after the last partial.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
         last_q  <= 1'b0;
         shift_q <= '0;
      end else if (i_clear) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         last_q <= 1'b0;
         if (i_valid) begin
            if (state_q == ST_IDLE) begin
               acc_q   <= i_bias + data_sext;
               shift_q <= i_shift;
               if (i_num_pass > CNT_WIDTH'(1)) begin
                  rem_q   <= i_num_pass - CNT_WIDTH'(1);
                  state_q <= ST_ACCUM;
               end else begin
                  rem_q  <= '0;
                  last_q <= 1'b1;
               end
            end else begin
               acc_q <= acc_q + data_sext;
               rem_q <= rem_q - CNT_WIDTH'(1);
               if (rem_q == CNT_WIDTH'(1)) begin
                  last_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
         end
      end
   end

   // One extra bit keeps acc + 2^(shift-1) from wrapping before the shift.
   always_comb begin
      acc_ext = {acc_q[ACC_WIDTH-1], acc_q};
      rnd     = '0;
      if (shift_q != 5'd0) rnd = (ACC_WIDTH+1)'(1) << (shift_q - 5'd1);
      r_d = (acc_ext + rnd) >>> shift_q;
   end

   always_comb begin
      sat_d = r_q[7:0];
      if (r_q > (ACC_WIDTH+1)'(INT8_MAX))      sat_d = 8'(INT8_MAX);
      else if (r_q < (ACC_WIDTH+1)'(INT8_MIN)) sat_d = 8'(INT8_MIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld_q <= 1'b0;
         s3_vld_q <= 1'b0;
      end else if (i_clear) begin
         s2_vld_q <= 1'b0;
         s3_vld_q <= 1'b0;
      end else begin
         s2_vld_q <= last_q;
         s3_vld_q <= s2_vld_q;
      end
   end

   always_ff @(posedge clk) begin
      r_q   <= r_d;
      sat_q <= sat_d;
   end

   assign fifo_pop = o_valid && i_ready;

   macc_out_fifo #(.WIDTH(8)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (i_clear),
      .push    (s3_vld_q),
      .wr_data (sat_q),
      .pop     (fifo_pop),
      .rd_data (o_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   ovf_q <= 1'b0;
      else if (i_clear)                             ovf_q <= 1'b0;
      else if (s3_vld_q && fifo_full && !fifo_pop)  ovf_q <= 1'b1;
   end

   assign o_valid    = !fifo_empty;
   assign o_overflow = ovf_q;
   assign o_busy     = (state_q == ST_ACCUM) || last_q || s2_vld_q || s3_vld_q;

endmodule

// File: tb/tb_macc_acc_requant.sv
module tb_macc_acc_requant;

   logic               clk;
   logic               rst_n;
   logic signed [20:0] i_data;
   logic               i_valid;
   logic        [7:0]  i_num_pass;
   logic signed [31:0] i_bias;
   logic        [4:0]  i_shift;
   logic               i_clear;
   logic signed [7:0]  o_data;
   logic               o_valid;
   logic               i_ready;
   logic               o_busy;
   logic               o_overflow;

   int tests;
   int fails;
   bit rand_ready;
   bit mon_en;
   logic signed [7:0] got_q[$];
   int                exp_q[$];

   typedef struct {
      string name;
      int    np;
      int    bias;
      int    shift;
      int    p0, p1, p2, p3;
      int    exp;
   } vec_t;

   vec_t vecs[$];

   macc_acc_requant dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_data     (i_data),
      .i_valid    (i_valid),
      .i_num_pass (i_num_pass),
      .i_bias     (i_bias),
      .i_shift    (i_shift),
      .i_clear    (i_clear),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_busy     (o_busy),
      .o_overflow (o_overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (mon_en && o_valid && i_ready) got_q.push_back(o_data);
   end

   task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) begin
         if (!i_ready) i_ready = 1'b1;
         else          i_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic drive(bit v, int d, int np, int b, int s);
      i_valid    = v;
      i_data     = 21'(d);
      i_num_pass = 8'(np);
      i_bias     = b;
      i_shift    = 5'(s);
   endtask

   function automatic vec_t mk(string name, int np, int b, int s,
                               int p0, int p1, int p2, int p3, int e);
      vec_t v;
      v.name = name; v.np = np; v.bias = b; v.shift = s;
      v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3; v.exp = e;
      return v;
   endfunction

   // Reference: sum everything as a wide integer, wrap to 32 bits, round half
   // up by adding 2^(shift-1), floor-divide by 2^shift, clamp to int8.
   function automatic int ref_out(int b, int s, int parts[$]);
      longint sum;
      int     acc;
      longint a;
      longint half;
      longint r;
      sum = b;
      foreach (parts[i]) sum += parts[i];
      acc  = int'(sum);
      a    = acc;
      half = (s > 0) ? (longint'(1) << (s - 1)) : 0;
      r    = (a + half) >>> s;
      if (r > 127)  return 127;
      if (r < -128) return -128;
      return int'(r);
   endfunction

   // Partials are issued back-to-back; later partials carry junk config that
   // must be ignored. Result must appear after the 3rd edge past the last one.
   task automatic run_vec(vec_t v);
      int n;
      int pp[4];
      n = (v.np == 0) ? 1 : v.np;
      pp[0] = v.p0; pp[1] = v.p1; pp[2] = v.p2; pp[3] = v.p3;
      for (int i = 0; i < n; i++) begin
         if (i == 0) drive(1'b1, pp[i], v.np, v.bias, v.shift);
         else        drive(1'b1, pp[i], $urandom_range(0, 255), int'($urandom), $urandom_range(0, 31));
         step();
      end
      i_valid = 1'b0;
      step();
      step();
      chk({v.name, "_early"}, o_valid, 0);
      step();
      chk({v.name, "_valid"}, o_valid, 1);
      chk({v.name, "_data"}, o_data, v.exp);
      step();
   endtask

   initial begin
      int parts[$];
      int np;
      int b;
      int s;
      tests = 0; fails = 0; rand_ready = 0; mon_en = 0;
      rst_n = 1'b0; i_clear = 1'b0; i_ready = 1'b1;
      drive(1'b0, 0, 1, 0, 0);

      vecs.push_back(mk("v3pass",   3, 100,         2, 200, -50, 30, 0, 70));
      vecs.push_back(mk("sat_hi",   1, 0,           0, 1000, 0, 0, 0, 127));
      vecs.push_back(mk("sat_lo",   1, 0,           0, -1000, 0, 0, 0, -128));
      vecs.push_back(mk("neg6",     1, 0,           2, -6, 0, 0, 0, -1));
      vecs.push_back(mk("np0",      0, 5,           0, 3, 0, 0, 0, 8));
      vecs.push_back(mk("rnd_up",   1, 0,           2, 6, 0, 0, 0, 2));
      vecs.push_back(mk("rnd_half", 1, 0,           2, -2, 0, 0, 0, 0));
      vecs.push_back(mk("rnd_neg",  2, 0,           2, -1, -2, 0, 0, -1));
      vecs.push_back(mk("wrap",     1, 2147483647,  0, 1, 0, 0, 0, -128));
      vecs.push_back(mk("edge127",  4, 19,          3, 100, 200, 300, 400, 127));
      vecs.push_back(mk("edge_128", 4, -2027,       3, 100, 200, 300, 400, -128));
      vecs.push_back(mk("shift31",  1, 1073741824, 31, 0, 0, 0, 0, 1));

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_ovf", o_overflow, 0);
      rst_n = 1'b1;
      step();

      foreach (vecs[i]) run_vec(vecs[i]);

      // Four results into a stalled 2-deep FIFO: two kept, two dropped.
      i_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 10 * (i + 1), 1, 0, 0);
         step();
      end
      i_valid = 1'b0;
      repeat (6) step();
      chk("stall_ovf", o_overflow, 1);
      chk("stall_valid", o_valid, 1);
      i_ready = 1'b1;
      chk("drain0", o_data, 10);
      step();
      chk("drain1_valid", o_valid, 1);
      chk("drain1", o_data, 20);
      step();
      chk("drain_empty", o_valid, 0);
      chk("ovf_sticky", o_overflow, 1);
      i_clear = 1'b1;
      step();
      i_clear = 1'b0;
      chk("ovf_clr", o_overflow, 0);

      // Full FIFO, push and pop land on the same edge: nothing lost.
      i_ready = 1'b0;
      drive(1'b1, 1, 1, 0, 0); step();
      drive(1'b1, 2, 1, 0, 0); step();
      i_valid = 1'b0;
      repeat (5) step();
      chk("full_head", o_data, 1);
      drive(1'b1, 3, 1, 0, 0);
      step();
      i_valid = 1'b0;
      step();
      step();
      i_ready = 1'b1;
      step();
      chk("pp_head2", o_data, 2);
      chk("pp_ovf", o_overflow, 0);
      step();
      chk("pp_head3", o_data, 3);
      step();
      chk("pp_empty", o_valid, 0);
      chk("pp_ovf_end", o_overflow, 0);

      // i_clear mid-accumulation; the same-cycle partial is discarded.
      drive(1'b1, 100, 4, 1000, 0); step();
      drive(1'b1, 100, 4, 1000, 0); step();
      i_valid = 1'b0;
      chk("acc_busy", o_busy, 1);
      i_clear = 1'b1;
      drive(1'b1, 5555, 1, 9999, 0);
      step();
      i_clear = 1'b0;
      i_valid = 1'b0;
      chk("clr_busy", o_busy, 0);
      run_vec(mk("after_clr", 4, 7, 1, 1, 2, 3, 4, 9));

      // Reset mid-accumulation abandons the partial result.
      drive(1'b1, 100, 4, 1000, 0); step();
      drive(1'b1, 100, 4, 1000, 0); step();
      i_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("rstmid_busy", o_busy, 0);
      step();
      rst_n = 1'b1;
      step();
      run_vec(mk("after_rst", 4, -20, 1, 10, 10, 10, 10, 10));

      // Random outputs of 3..6 partials with gaps and a flickering i_ready.
      rand_ready = 1;
      mon_en = 1;
      for (int k = 0; k < 30; k++) begin
         np = $urandom_range(3, 6);
         b  = int'($urandom) >>> $urandom_range(8, 31);
         s  = $urandom_range(0, 24);
         parts.delete();
         for (int i = 0; i < np; i++) parts.push_back(int'($urandom_range(0, 2097151)) - 1048576);
         exp_q.push_back(ref_out(b, s, parts));
         for (int i = 0; i < np; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
               i_valid = 1'b0;
               step();
            end
            if (i == 0) drive(1'b1, parts[i], np, b, s);
            else        drive(1'b1, parts[i], $urandom_range(0, 255), int'($urandom), $urandom_range(0, 31));
            step();
         end
      end
      i_valid = 1'b0;
      for (int c = 0; c < 60 && got_q.size() < exp_q.size(); c++) step();
      rand_ready = 0;
      mon_en = 0;
      i_ready = 1'b1;
      chk("rand_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("rand_out%0d", i), got_q[i], exp_q[i]);
      chk("rand_ovf", o_overflow, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
